// File: rtl/pheap_level_stage_if.sv
// Token channels of one pheap level: in_* from the parent level, out_* toward the child level.
interface pheap_level_stage_if #(
    parameter int unsigned LEVEL = 2,
    parameter int unsigned KW    = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [LEVEL-2:0] in_pos;
    logic [KW-1:0]    in_val;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_op;
    logic [LEVEL-1:0] out_pos;
    logic [KW-1:0]    out_val;

    // master feeds tokens in and absorbs tokens out; slave is the level stage
    modport master (
        output in_valid, in_op, in_pos, in_val, out_ready,
        input  in_ready, out_valid, out_op, out_pos, out_val
    );
    modport slave (
        input  in_valid, in_op, in_pos, in_val, out_ready,
        output in_ready, out_valid, out_op, out_pos, out_val
    );
endinterface

// File: rtl/pheap_level_stage.sv
// One level of the pipelined min-heap: owns this level's nodes, applies INSERT/REMOVE
// tokens, forwards tokens to the next level and serves child-pair reads to the parent.
module pheap_level_stage #(
    parameter int unsigned LEVEL = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned KW    = 8,
    localparam int unsigned PW   = (LEVEL > 2) ? LEVEL - 2 : 1
) (
    input  logic               clk,
    input  logic               rst,
    pheap_level_stage_if.slave tok,
    input  logic               ch_idle,
    output logic               ch_rd_en,
    output logic [LEVEL-2:0]   ch_rd_pair,
    input  logic               ch_l_occ,
    input  logic               ch_r_occ,
    input  logic [KW-1:0]      ch_l_val,
    input  logic [KW-1:0]      ch_r_val,
    output logic               idle,
    input  logic               pr_rd_en,
    input  logic [PW-1:0]      pr_rd_pair,
    output logic               pr_l_occ,
    output logic               pr_r_occ,
    output logic [KW-1:0]      pr_l_val,
    output logic [KW-1:0]      pr_r_val,
    output logic               err
);
    localparam int unsigned NW   = LEVEL - 1;
    localparam int unsigned N    = 1 << NW;
    localparam bit          LEAF = (LEVEL == DEPTH);
    localparam int unsigned FW   = LEAF ? 1 : DEPTH - LEVEL;
    localparam int unsigned FMAX = (1 << (DEPTH - LEVEL)) - 1;
    localparam logic [1:0]  OP_INS = 2'b01;
    localparam logic [1:0]  OP_REM = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_SEND} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [NW-1:0]    pos_q, pos_d;
    logic [KW-1:0]    key_q, key_d;
    logic [1:0]       out_op_q, out_op_d;
    logic [LEVEL-1:0] out_pos_q, out_pos_d;
    logic [KW-1:0]    out_val_q, out_val_d;

    logic [KW-1:0]    val_q [N];
    logic [KW-1:0]    val_d [N];
    logic             occ_q [N];
    logic             occ_d [N];
    logic [FW-1:0]    lfree_q [N];
    logic [FW-1:0]    lfree_d [N];
    logic [FW-1:0]    rfree_q [N];
    logic [FW-1:0]    rfree_d [N];

    logic             pr_l_occ_q, pr_l_occ_d, pr_r_occ_q, pr_r_occ_d;
    logic [KW-1:0]    pr_l_val_q, pr_l_val_d, pr_r_val_q, pr_r_val_d;

    logic [PW:0]      pr_pair_x2;
    logic [NW-1:0]    pr_l_idx, pr_r_idx;
    logic             unused_pair;
    logic             c_l_occ, c_r_occ, take_l;
    logic [KW-1:0]    pass_val;

    // At LEVEL 2 the pair index is dropped by the slice: node pair is always {0,1}
    assign pr_pair_x2  = {pr_rd_pair, 1'b0};
    assign pr_l_idx    = pr_pair_x2[NW-1:0];
    assign pr_r_idx    = pr_l_idx | NW'(1);
    assign unused_pair = ^pr_pair_x2;

    assign c_l_occ = ch_l_occ && !LEAF;
    assign c_r_occ = ch_r_occ && !LEAF;

    assign tok.in_ready  = (state_q == S_IDLE);
    assign idle          = (state_q == S_IDLE);
    assign tok.out_valid = (state_q == S_SEND);
    assign tok.out_op    = out_op_q;
    assign tok.out_pos   = out_pos_q;
    assign tok.out_val   = out_val_q;
    assign ch_rd_pair    = pos_q;
    assign pr_l_occ      = pr_l_occ_q;
    assign pr_r_occ      = pr_r_occ_q;
    assign pr_l_val      = pr_l_val_q;
    assign pr_r_val      = pr_r_val_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pos_d      = pos_q;
        key_d      = key_q;
        out_op_d   = out_op_q;
        out_pos_d  = out_pos_q;
        out_val_d  = out_val_q;
        val_d      = val_q;
        occ_d      = occ_q;
        lfree_d    = lfree_q;
        rfree_d    = rfree_q;
        err        = 1'b0;
        ch_rd_en   = 1'b0;
        take_l     = 1'b0;
        pass_val   = '0;
        pr_l_occ_d = pr_l_occ_q;
        pr_r_occ_d = pr_r_occ_q;
        pr_l_val_d = pr_l_val_q;
        pr_r_val_d = pr_r_val_q;

        // Reads sample the pre-write array, so a same-cycle write is not visible
        if (pr_rd_en) begin
            pr_l_occ_d = occ_q[pr_l_idx];
            pr_r_occ_d = occ_q[pr_r_idx];
            pr_l_val_d = val_q[pr_l_idx];
            pr_r_val_d = val_q[pr_r_idx];
        end

        unique case (state_q)
            S_IDLE: begin
                if (tok.in_valid) begin
                    op_d  = tok.in_op;
                    pos_d = tok.in_pos;
                    key_d = tok.in_val;
                    if (tok.in_op == OP_INS) begin
                        state_d = S_EXEC;
                    end else if (tok.in_op == OP_REM) begin
                        state_d = LEAF ? S_EXEC : S_REQ;
                    end
                end
            end
            S_REQ: begin
                ch_rd_en = ch_idle;
                if (ch_idle) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (op_q == OP_INS) begin
                    if (!occ_q[pos_q]) begin
                        val_d[pos_q] = key_q;
                        occ_d[pos_q] = 1'b1;
                    end else if (lfree_q[pos_q] == '0 && rfree_q[pos_q] == '0) begin
                        err = 1'b1;
                    end else begin
                        if (key_q < val_q[pos_q]) begin
                            val_d[pos_q] = key_q;
                            pass_val     = val_q[pos_q];
                        end else begin
                            pass_val     = key_q;
                        end
                        out_op_d  = OP_INS;
                        out_val_d = pass_val;
                        if (lfree_q[pos_q] != '0) begin
                            lfree_d[pos_q] = lfree_q[pos_q] - FW'(1);
                            out_pos_d      = {pos_q, 1'b0};
                        end else begin
                            rfree_d[pos_q] = rfree_q[pos_q] - FW'(1);
                            out_pos_d      = {pos_q, 1'b1};
                        end
                        state_d = S_SEND;
                    end
                end else begin
                    if (!occ_q[pos_q]) begin
                        err = 1'b1;
                    end else if (!c_l_occ && !c_r_occ) begin
                        occ_d[pos_q] = 1'b0;
                    end else begin
                        take_l    = c_l_occ && (!c_r_occ || ch_l_val <= ch_r_val);
                        out_op_d  = OP_REM;
                        out_val_d = '0;
                        if (take_l) begin
                            val_d[pos_q]   = ch_l_val;
                            lfree_d[pos_q] = lfree_q[pos_q] + FW'(1);
                            out_pos_d      = {pos_q, 1'b0};
                        end else begin
                            val_d[pos_q]   = ch_r_val;
                            rfree_d[pos_q] = rfree_q[pos_q] + FW'(1);
                            out_pos_d      = {pos_q, 1'b1};
                        end
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (tok.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            pos_q      <= '0;
            key_q      <= '0;
            out_op_q   <= '0;
            out_pos_q  <= '0;
            out_val_q  <= '0;
            pr_l_occ_q <= 1'b0;
            pr_r_occ_q <= 1'b0;
            pr_l_val_q <= '0;
            pr_r_val_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                val_q[i]   <= '0;
                occ_q[i]   <= 1'b0;
                lfree_q[i] <= FW'(FMAX);
                rfree_q[i] <= FW'(FMAX);
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pos_q      <= pos_d;
            key_q      <= key_d;
            out_op_q   <= out_op_d;
            out_pos_q  <= out_pos_d;
            out_val_q  <= out_val_d;
            pr_l_occ_q <= pr_l_occ_d;
            pr_r_occ_q <= pr_r_occ_d;
            pr_l_val_q <= pr_l_val_d;
            pr_r_val_q <= pr_r_val_d;
            val_q      <= val_d;
            occ_q      <= occ_d;
            lfree_q    <= lfree_d;
            rfree_q    <= rfree_d;
        end
    end
endmodule
